// File: rtl/noc_cfg_pkg.sv
// Shared types and constants for the mesh configuration scheduler.
package noc_cfg_pkg;

    localparam int CFG_W  = 11;
    localparam int NUM_PE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } drv_state_t;

    typedef logic [1:0] pe_idx_t;

endpackage

// File: rtl/cfg_pe_driver.sv
// Per-PE configuration driver: holds a granted word on the bus, then forces a zero gap.
// state | meaning
// IDLE  | bus zero, ready for a grant
// HOLD  | bus carries the word for HOLD_CYCLES cycles
// GAP   | bus zero for GAP_CYCLES cycles; a new grant may land on the last one
module cfg_pe_driver
    import noc_cfg_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             grant,
    input  logic [CFG_W-1:0] word,
    output logic [CFG_W-1:0] configure,
    output logic             avail,
    output logic             active
);

    localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);

    drv_state_t       state, state_nxt;
    logic [15:0]      cnt, cnt_nxt;
    logic [CFG_W-1:0] word_q, word_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            word_q <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            word_q <= word_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        word_nxt  = word_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = HOLD;
                    cnt_nxt   = HOLD_LOAD;
                    word_nxt  = word;
                end
            end
            HOLD: begin
                if (cnt == 16'd0) begin
                    state_nxt = GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            GAP: begin
                if (cnt == 16'd0) begin
                    if (grant) begin
                        state_nxt = HOLD;
                        cnt_nxt   = HOLD_LOAD;
                        word_nxt  = word;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The final gap cycle counts as free so back-to-back words see exactly GAP_CYCLES zeros.
    assign avail     = (state == IDLE) || ((state == GAP) && (cnt == 16'd0));
    assign active    = (state != IDLE);
    assign configure = (state == HOLD) ? word_q : '0;

endmodule

// File: rtl/mesh_cfg_scheduler.sv
// Queues host configuration words per PE and launches them round-robin into the 2x2 mesh.
// Optional launch statistics are enabled with `define CFG_SCHED_STATS_EN.
module mesh_cfg_scheduler
    import noc_cfg_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int GAP_CYCLES  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_pe,
    input  logic [CFG_W-1:0]  cfg_word,
    output logic              cfg_ready,
    input  logic [NUM_PE-1:0] processor_ready_signals,
    output logic [CFG_W-1:0]  p0_configure,
    output logic [CFG_W-1:0]  p1_configure,
    output logic [CFG_W-1:0]  p2_configure,
    output logic [CFG_W-1:0]  p3_configure,
    output logic [NUM_PE-1:0] pe_busy,
    output logic [63:0]       issue_count
);

    logic [NUM_PE-1:0] slot_full;
    logic [CFG_W-1:0]  slot_word [NUM_PE];
    logic [CFG_W-1:0]  configure [NUM_PE];
    logic [NUM_PE-1:0] avail, active, eligible, grant;
    pe_idx_t           last_grant, grant_pe, cand;
    logic              grant_any, load;

    assign cfg_ready = !slot_full[cfg_pe];
    // Zero words are consumed by the handshake but never occupy a slot.
    assign load      = cfg_valid && cfg_ready && (cfg_word != '0);
    assign eligible  = slot_full & avail & processor_ready_signals;

    always_comb begin
        grant_any = 1'b0;
        grant_pe  = last_grant;
        cand      = last_grant;
        grant     = '0;
        for (int i = 1; i <= NUM_PE; i++) begin
            cand = last_grant + pe_idx_t'(i);
            if (!grant_any && eligible[cand]) begin
                grant_any = 1'b1;
                grant_pe  = cand;
            end
        end
        if (grant_any) grant[grant_pe] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot_full  <= '0;
            last_grant <= pe_idx_t'(NUM_PE - 1);
            for (int i = 0; i < NUM_PE; i++) slot_word[i] <= '0;
        end else begin
            if (grant_any) last_grant <= grant_pe;
            for (int i = 0; i < NUM_PE; i++) begin
                if (grant[i]) slot_full[i] <= 1'b0;
                if (load && (cfg_pe == pe_idx_t'(i))) begin
                    slot_full[i] <= 1'b1;
                    slot_word[i] <= cfg_word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PE; g++) begin : g_drv
        cfg_pe_driver #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .GAP_CYCLES (GAP_CYCLES)
        ) u_drv (
            .clock    (clock),
            .reset    (reset),
            .grant    (grant[g]),
            .word     (slot_word[g]),
            .configure(configure[g]),
            .avail    (avail[g]),
            .active   (active[g])
        );
    end

    assign p0_configure = configure[0];
    assign p1_configure = configure[1];
    assign p2_configure = configure[2];
    assign p3_configure = configure[3];
    assign pe_busy      = active | slot_full;

`ifdef CFG_SCHED_STATS_EN
    logic [15:0] launches [NUM_PE];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PE; i++) launches[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PE; i++)
                if (grant[i]) launches[i] <= launches[i] + 16'd1;
        end
    end

    assign issue_count = {launches[3], launches[2], launches[1], launches[0]};
`else
    assign issue_count = '0;
`endif

endmodule
